if_id_skid_stage: RTL and testbench

Parametrised IF/ID pipeline boundary that replaces the plain fetch/decode register with a valid/ready stage. It holds up to two beats (main plus skid) so that `in_ready` is driven directly from a flop. It supports hazard stall, branch flush with NOP bubble insertion, and a saturating stall-cycle counter. It sits between the fetch unit (PC + instruction memory) and the decoder.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_slot.sv | 58 +++++
 rtl/if_id_skid_stage.sv | 128 ++++++++++++
 tb/tb_if_id_skid_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, the NOP bubble encoding and
// the {valid, pc, instr} slot record used between fetch and decode.
package pipe_pkg;

  localparam int PC_W_DEF    = 64;
  localparam int INSTR_W_DEF = 32;

  // addi x0,x0,0
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic                   valid;
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } slot_t;

endpackage

// File: rtl/pipe_slot.sv
// One {valid, pc, instr} holding register. Clearing (reset or clr_i) turns
// it into an empty bubble; load_i captures a new beat.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               valid_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_d, valid_q;
  logic [PC_W-1:0]    pc_d, pc_q;
  logic [INSTR_W-1:0] instr_d, instr_q;

  // Clear beats load, so a flush always leaves a clean bubble behind.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clr_i) begin
      valid_d = 1'b0;
      pc_d    = '0;
      instr_d = NOP_INSTR;
    end else if (load_i) begin
      valid_d = valid_i;
      pc_d    = pc_i;
      instr_d = instr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID boundary as a two-entry valid/ready stage (main + skid) so that
// in_ready comes straight from a flop; adds flush bubbles and a stall counter.
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter int                 CNT_W     = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic               mainValid, skidValid;
  logic [PC_W-1:0]    mainPc, skidPc;
  logic [INSTR_W-1:0] mainInstr, skidInstr;

  logic               fireIn, take, blocked, mainFree;
  logic               mainLoad, mainValidIn;
  logic [PC_W-1:0]    mainPcIn;
  logic [INSTR_W-1:0] mainInstrIn;
  logic               skidLoad, skidClr, skidValidNext;

  logic               inReady_d, inReady_q;
  logic [CNT_W-1:0]   stallCnt_d, stallCnt_q;

  always_comb begin
    fireIn   = in_valid & inReady_q;
    take     = mainValid & out_ready & ~stall;
    blocked  = mainValid & ~take;
    mainFree = ~mainValid | take;

    // A free main slot always reloads: the skid beat is older than any new input.
    mainLoad    = mainFree;
    mainValidIn = 1'b0;
    mainPcIn    = '0;
    mainInstrIn = NOP_INSTR;
    if (skidValid) begin
      mainValidIn = 1'b1;
      mainPcIn    = skidPc;
      mainInstrIn = skidInstr;
    end else if (fireIn) begin
      mainValidIn = 1'b1;
      mainPcIn    = pc_in;
      mainInstrIn = instr_in;
    end

    skidClr  = mainFree & skidValid;
    skidLoad = ~mainFree & fireIn;

    skidValidNext = skidValid;
    if (flush || skidClr) begin
      skidValidNext = 1'b0;
    end else if (skidLoad) begin
      skidValidNext = 1'b1;
    end
    inReady_d = ~skidValidNext;

    stallCnt_d = stallCnt_q;
    if (blocked && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
  end

  pipe_slot #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) mainSlot (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (flush),
    .load_i  (mainLoad),
    .valid_i (mainValidIn),
    .pc_i    (mainPcIn),
    .instr_i (mainInstrIn),
    .valid_o (mainValid),
    .pc_o    (mainPc),
    .instr_o (mainInstr)
  );

  pipe_slot #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) skidSlot (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (flush | skidClr),
    .load_i  (skidLoad),
    .valid_i (1'b1),
    .pc_i    (pc_in),
    .instr_i (instr_in),
    .valid_o (skidValid),
    .pc_o    (skidPc),
    .instr_o (skidInstr)
  );

  // Flush deliberately leaves the stall counter alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      inReady_q  <= 1'b1;
      stallCnt_q <= '0;
    end else begin
      inReady_q  <= inReady_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = mainValid;
  assign pc_out    = mainPc;
  assign instr_out = mainInstr;
  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for the IF/ID skid stage: reset, streaming, stall/skid,
// flush and counter saturation with hand-computed expectations.
module tb_if_id_skid_stage;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instr_in;
  logic               stall;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic [CNT_W-1:0]   stall_cnt;

  int checkCount = 0;
  int errorCount = 0;

  if_id_skid_stage #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pc_out    (pc_out),
    .instr_out (instr_out),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction words are derived from the PC so ordering mistakes show up twice.
  function automatic logic [31:0] instrFor(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic stl, input logic fl, input logic rdy);
    in_valid  = v;
    pc_in     = {32'h0, pc};
    instr_in  = instrFor(pc);
    stall     = stl;
    flush     = fl;
    out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [31:0] pc);
    checkOutput({tag, " valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, " pc"}, pc_out, {32'h0, pc});
    checkOutput({tag, " instr"}, 64'(instr_out), 64'(instrFor(pc)));
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, " valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, " instr"}, 64'(instr_out), 64'(NOP));
  endtask

  initial begin
    // Reset with a beat being offered; it must be dropped.
    reset = 1'b1;
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
    step();
    step();
    checkEmpty("reset");
    checkOutput("reset pc", pc_out, 64'h0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset cnt", 64'(stall_cnt), 64'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    checkEmpty("idle");

    // Streaming: one beat per cycle, one cycle of latency.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b1);
      step();
      checkBeat("stream", 32'(i * 4));
      checkOutput("stream in_ready", 64'(in_ready), 64'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    checkEmpty("stream drain");
    checkOutput("stream cnt", 64'(stall_cnt), 64'd0);

    // Stall: main holds 0x10, skid takes 0x14, 0x18 waits upstream.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b1);
    step();
    checkBeat("stall load", 32'h10);
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 1'b1);
    step();
    checkBeat("stall hold1", 32'h10);
    checkOutput("stall ready1", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'h18, 1'b1, 1'b0, 1'b1);
    step();
    checkBeat("stall hold2", 32'h10);
    checkOutput("stall ready2", 64'(in_ready), 64'd0);
    step();
    checkBeat("stall hold3", 32'h10);
    checkOutput("stall cnt", 64'(stall_cnt), 64'd3);
    stall = 1'b0;
    step();
    checkBeat("release skid", 32'h14);
    checkOutput("release ready", 64'(in_ready), 64'd1);
    step();
    checkBeat("release upstream", 32'h18);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    checkEmpty("release drain");
    checkOutput("release cnt", 64'(stall_cnt), 64'd3);

    // Flush with both slots occupied.
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 1'b1);
    step();
    checkBeat("fill main", 32'h20);
    applyStimulus(1'b1, 32'h24, 1'b1, 1'b0, 1'b1);
    step();
    checkBeat("fill skid", 32'h20);
    checkOutput("fill ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    step();
    checkEmpty("flush");
    checkOutput("flush pc", pc_out, 64'h0);
    checkOutput("flush ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkEmpty("post flush");
    end

    // Flush coincident with an offered beat drops it.
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b1, 1'b1);
    step();
    checkEmpty("flush drop");
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
    step();
    checkBeat("after flush", 32'h40);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    checkEmpty("after flush drain");

    // Counter saturation with a 4-bit counter.
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("sat reset cnt", 64'(stall_cnt), 64'd0);
    applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
    step();
    checkBeat("sat load", 32'h50);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) checkOutput("sat cnt14", 64'(stall_cnt), 64'd14);
      if (i == 15) checkOutput("sat cnt15", 64'(stall_cnt), 64'd15);
    end
    checkOutput("sat cnt20", 64'(stall_cnt), 64'd15);
    checkBeat("sat held", 32'h50);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("sat cleared", 64'(stall_cnt), 64'd0);
    checkEmpty("sat cleared");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
